// File: rtl/dtree_seq_engine_if.sv
// Handshake bundle for dtree_seq_engine: node-config port, feature input stream, result stream.
// DTREE_DEPTH_OUT_EN adds out_depth (internal nodes traversed for the held result).
interface dtree_seq_engine_if #(
    parameter int N_FEAT  = 7,
    parameter int FEAT_W  = 8,
    parameter int N_NODES = 16,
    parameter int CLASS_W = 5
`ifdef DTREE_DEPTH_OUT_EN
    , parameter int MAX_DEPTH = 8
`endif
);
    localparam int FI_W   = $clog2(N_FEAT);
    localparam int SH_W   = $clog2(FEAT_W);
    localparam int NI_W   = $clog2(N_NODES);
    localparam int NODE_W = 1 + FI_W + SH_W + FEAT_W + 2 * NI_W;

    logic                     cfg_we;
    logic [NI_W-1:0]          cfg_addr;
    logic [NODE_W-1:0]        cfg_data;
    logic                     cfg_ready;
    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_feat;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLASS_W-1:0]       out_class;
    logic                     out_err;
`ifdef DTREE_DEPTH_OUT_EN
    logic [$clog2(MAX_DEPTH+1)-1:0] out_depth;
`endif

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_feat, out_ready,
        input  cfg_ready, in_ready, out_valid, out_class, out_err
`ifdef DTREE_DEPTH_OUT_EN
        , input out_depth
`endif
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_feat, out_ready,
        output cfg_ready, in_ready, out_valid, out_class, out_err
`ifdef DTREE_DEPTH_OUT_EN
        , output out_depth
`endif
    );
endinterface

// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier: register node table, one node per clock, one shared comparator.
// Optional DTREE_DEPTH_OUT_EN exposes the walk's internal-node count on out_depth.
module dtree_seq_engine #(
    parameter int N_FEAT    = 7,
    parameter int FEAT_W    = 8,
    parameter int N_NODES   = 16,
    parameter int CLASS_W   = 5,
    parameter int MAX_DEPTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    dtree_seq_engine_if.slave bus
);
    localparam int FI_W   = $clog2(N_FEAT);
    localparam int SH_W   = $clog2(FEAT_W);
    localparam int NI_W   = $clog2(N_NODES);
    localparam int NODE_W = 1 + FI_W + SH_W + FEAT_W + 2 * NI_W;
    localparam int DW     = $clog2(MAX_DEPTH + 1);

    localparam logic [NI_W:0]   NN = (NI_W+1)'(N_NODES);
    localparam logic [FI_W:0]   NF = (FI_W+1)'(N_FEAT);
    localparam logic [DW-1:0]   MD = DW'(MAX_DEPTH);
    localparam logic [NODE_W-1:0] LEAF_RST = {1'b1, {(NODE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
    state_t state, state_d;

    logic [NODE_W-1:0]        tbl [N_NODES];
    logic [N_FEAT*FEAT_W-1:0] feat_q;
    logic [NI_W-1:0]          ptr, ptr_d;
    logic [DW-1:0]            step, step_d, step_inc;
    logic [CLASS_W-1:0]       cls, cls_d;
    logic                     err, err_d;

    logic                     n_leaf;
    logic [FI_W-1:0]          n_feat;
    logic [SH_W-1:0]          n_sh;
    logic signed [FEAT_W-1:0] n_thr;
    logic [NI_W-1:0]          n_l, n_r, child;
    logic signed [FEAT_W-1:0] fval, fshift;
    logic                     feat_bad, child_bad, addr_ok;

    assign {n_leaf, n_feat, n_sh, n_thr, n_l, n_r} = tbl[ptr];

    always_comb begin
        fval = '0;
        for (int i = 0; i < N_FEAT; i++)
            if (n_feat == FI_W'(i)) fval = feat_q[i*FEAT_W +: FEAT_W];
    end

    // Arithmetic shift keeps only the top slice of the feature, so the compare acts on an MSB field.
    assign fshift    = fval >>> n_sh;
    assign child     = (fshift <= n_thr) ? n_l : n_r;
    assign feat_bad  = {1'b0, n_feat} >= NF;
    assign child_bad = {1'b0, child} >= NN;
    assign step_inc  = step + DW'(1);
    assign addr_ok   = {1'b0, bus.cfg_addr} < NN;

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        step_d  = step;
        cls_d   = cls;
        err_d   = err;
        case (state)
            IDLE: if (bus.in_valid) begin
                state_d = WALK;
                ptr_d   = '0;
                step_d  = '0;
            end
            WALK: begin
                if (n_leaf) begin
                    cls_d   = n_thr[CLASS_W-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (feat_bad || child_bad || step_inc == MD) begin
                    cls_d   = '0;
                    err_d   = 1'b1;
                    step_d  = step_inc;
                    state_d = DONE;
                end else begin
                    ptr_d  = child;
                    step_d = step_inc;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            step   <= '0;
            cls    <= '0;
            err    <= 1'b0;
            feat_q <= '0;
            for (int i = 0; i < N_NODES; i++) tbl[i] <= LEAF_RST;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            step  <= step_d;
            cls   <= cls_d;
            err   <= err_d;
            // Table writes land before the walk's first read, so a same-cycle accept sees them.
            if (state == IDLE) begin
                if (bus.in_valid) feat_q <= bus.in_feat;
                if (bus.cfg_we && addr_ok) tbl[bus.cfg_addr] <= bus.cfg_data;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.cfg_ready = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_class = cls;
    assign bus.out_err   = err;
`ifdef DTREE_DEPTH_OUT_EN
    assign bus.out_depth = step;
`endif
endmodule
